regfile_bank: RTL
=================

# regfile_bank

Parametrised successor to the fixed 14-entry, 1-bit register-file slice used in the extracted Z80 netlist. It holds NREGS registers of WIDTH bits on two precharged, wired-AND buses (left/address and right/data) joined by a pass switch. Left-side registers can be incremented or decremented in place, as the Z80 address incrementer does. It sits between the extracted control logic and the address/data bus models, running on the emulation clock.

## Interface
- WIDTH, 8: bits per register and per bus.
- NREGS, 14: number of registers; index 0 is the lowest.
- NLEFT, 2: registers 0..NLEFT-1 sit on the left bus, NLEFT..NREGS-1 on the right bus; 1 ≤ NLEFT < NREGS.
- RESET_VAL, 0: reset contents of every register.

- eclk  in  1  emulation clock, rising edge.
- erst_n  in  1  reset, asynchronous, active-low.
- join  in  1  bus switch: 1 = left and right buses joined, 0 = split.
- sel  in  NREGS  register select, one bit per register; any number may be set.
- l_wr  in  1  left-bus driver enable.
- l_din  in  WIDTH  left-bus driver data.
- r_wr  in  1  right-bus driver enable.
- r_din  in  WIDTH  right-bus driver data.
- l_inc, l_dec  in  1 each  in-place increment/decrement of the selected left registers; present only with REGFILE_INCDEC_EN.
- l_dout  out  WIDTH  registered left-bus value.
- r_dout  out  WIDTH  registered right-bus value.
- l_cy  out  1  registered wrap flag; present only with REGFILE_INCDEC_EN.

## Operation
- Each bus is evaluated every cycle as the bitwise AND of all of its pull-downs, starting from all-ones (precharge).
- Split mode (join=0):
  - Left bus: l_din if l_wr; otherwise the AND of the selected registers below NLEFT.
  - Right bus: r_din if r_wr; otherwise the AND of the selected registers at NLEFT and above.
- Joined mode (join=1):
  - Both buses carry the same value: the AND of l_din (if l_wr) and r_din (if r_wr).
  - If neither driver is enabled, that value is the AND of all selected registers.
- If nothing pulls a bus down, that bus is all-ones.
- Register writes, at the rising edge:
  - Selected left register i gets the left-bus value when l_wr=1, or when join=1 and r_wr=1.
  - Selected right register j gets the right-bus value when r_wr=1, or when join=1 and l_wr=1.
  - Unselected registers hold.
- Outputs: l_dout and r_dout register the bus values every cycle. They are not inverted.
- Reset (erst_n low, takes effect immediately):
  - Registers go to RESET_VAL.
  - l_dout and r_dout go to all-ones.
  - l_cy goes to 0.
  - Deasserting reset mid-operation resumes with no other state.

## Timing
- A bus value in cycle n appears on the dout outputs in cycle n+1.
- A write in cycle n is visible through a register read in cycle n+1.
- A same-cycle write followed by a read returns the driven value, because the bus carries the driver.
- There is no handshake: every cycle is one independent bus cycle.
- Inc/dec result lands at the edge ending cycle n; l_cy is valid in cycle n+1.

## Configuration
- REGFILE_INCDEC_EN defined:
  - l_inc, l_dec and l_cy exist.
  - With join=0, l_wr=0 and exactly one of l_inc/l_dec set, every selected left register gets (left-bus value ± 1) mod 2^WIDTH. The left-bus value is the AND of the selected left registers.
  - l_cy goes to 1 on an all-ones→0 increment or a 0→all-ones decrement, and to 0 otherwise.
  - l_inc and l_dec both set: no write, l_cy=0.
  - l_wr=1 or join=1: inc/dec are ignored.
  - l_dout shows the pre-increment bus value.
- REGFILE_INCDEC_EN undefined: the ports are absent, and l_cy logic and the adder are not built.

## Structure
- Package regfile_pkg holds the shared constants and helper:
  - Bus precharge constant (all-ones of WIDTH).
  - RESET_VAL default.
  - An AND-reduce-over-selected function, used for both buses.
- One sub-module, regfile_bus_resolve:
  - Computes one bus value from the driver enable/data plus the masked register AND.
  - Instantiated for the left bus, the right bus, and the joined case.

## Test plan
- Reset with RESET_VAL=0 → l_dout=r_dout=8'hFF, l_cy=0. Then sel=reg3 read → r_dout=8'h00 one cycle later.
- Split write: join=0, r_wr=1, r_din=8'hA5, sel=reg3|reg0 → reg3=A5 and reg0 unchanged. Read reg3 → r_dout=A5.
- Joined write: join=1, l_wr=1, l_din=8'h3C, sel=reg1|reg5 → both registers =3C. Read both → l_dout=r_dout=3C.
- Wired-AND read: reg2=F0, reg4=3C, sel=reg2|reg4, no drivers → r_dout=8'h30.
- Incdec (macro on): reg0=FF, l_inc, sel=reg0 → reg0=00, l_cy=1 next cycle. Then l_dec → reg0=FF, l_cy=1. Then l_inc+l_dec together → no change, l_cy=0.
- Async reset mid-write (erst_n low between edges) → registers at RESET_VAL immediately; the pending write is lost.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the wired-AND helper for regfile_bank.
// Bus columns are evaluated one bit at a time over a mask of up to MAX_REGS registers.
package regfile_pkg;

   localparam int unsigned DEF_WIDTH     = 8;
   localparam int unsigned DEF_NREGS     = 14;
   localparam int unsigned DEF_NLEFT     = 2;
   localparam int unsigned DEF_RESET_VAL = 0;
   localparam int unsigned MAX_REGS      = 64;

   localparam logic [DEF_WIDTH-1:0] BUS_PRECHARGE = '1;

   typedef logic [MAX_REGS-1:0] regmask_t;

   // One bus bit: precharged high, pulled low by any selected register holding 0.
   function automatic logic and_sel(input regmask_t bits, input regmask_t sel);
      return &(bits | ~sel);
   endfunction

endpackage

// File: rtl/regfile_bus_resolve.sv
// regfile_bus_resolve: resolves one precharged wired-AND bus from up to two
// drivers and the AND of the selected registers (registers only pull when undriven).
module regfile_bus_resolve #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             wr_a,
   input  logic [WIDTH-1:0] din_a,
   input  logic             wr_b,
   input  logic [WIDTH-1:0] din_b,
   input  logic [WIDTH-1:0] reg_and,
   output logic [WIDTH-1:0] bus
);

   always_comb begin
      bus = '1;
      if (wr_a) bus = bus & din_a;
      if (wr_b) bus = bus & din_b;
      if (!wr_a && !wr_b) bus = bus & reg_and;
   end

endmodule

// File: rtl/regfile_bank.sv
// regfile_bank: NREGS x WIDTH register file on split/joinable wired-AND buses.
// Optional in-place increment/decrement of left registers under `REGFILE_INCDEC_EN.
module regfile_bank
   import regfile_pkg::*;
#(
   parameter int unsigned      WIDTH     = DEF_WIDTH,
   parameter int unsigned      NREGS     = DEF_NREGS,
   parameter int unsigned      NLEFT     = DEF_NLEFT,
   parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
   input  logic             eclk,
   input  logic             erst_n,
   input  logic             join_en,   // bus switch; "join" is a reserved word
   input  logic [NREGS-1:0] sel,
   input  logic             l_wr,
   input  logic [WIDTH-1:0] l_din,
   input  logic             r_wr,
   input  logic [WIDTH-1:0] r_din,
`ifdef REGFILE_INCDEC_EN
   input  logic             l_inc,
   input  logic             l_dec,
   output logic             l_cy,
`endif
   output logic [WIDTH-1:0] l_dout,
   output logic [WIDTH-1:0] r_dout
);

   if (NREGS > MAX_REGS || NLEFT < 1 || NLEFT >= NREGS) begin : g_bad_cfg
      $error("regfile_bank: unsupported NREGS/NLEFT");
   end

   logic [WIDTH-1:0] regs [NREGS];
   regmask_t         sel_l, sel_r, sel_all, col;
   logic [WIDTH-1:0] l_and, r_and, a_and;
   logic [WIDTH-1:0] l_split, r_split, j_bus;
   logic [WIDTH-1:0] l_bus, r_bus;
   logic             l_load, r_load;

   always_comb begin
      sel_l   = '0;
      sel_r   = '0;
      sel_all = '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
         sel_all[i] = sel[i];
         if (i < NLEFT) sel_l[i] = sel[i];
         else           sel_r[i] = sel[i];
      end
   end

   // Transpose one bit column at a time so the package helper serves every bus.
   always_comb begin
      l_and = '1;
      r_and = '1;
      a_and = '1;
      col   = '0;
      for (int unsigned b = 0; b < WIDTH; b++) begin
         col = '0;
         for (int unsigned i = 0; i < NREGS; i++) col[i] = regs[i][b];
         l_and[b] = and_sel(col, sel_l);
         r_and[b] = and_sel(col, sel_r);
         a_and[b] = and_sel(col, sel_all);
      end
   end

   regfile_bus_resolve #(.WIDTH(WIDTH)) u_left (
      .wr_a(l_wr), .din_a(l_din), .wr_b(1'b0), .din_b('1),
      .reg_and(l_and), .bus(l_split)
   );

   regfile_bus_resolve #(.WIDTH(WIDTH)) u_right (
      .wr_a(r_wr), .din_a(r_din), .wr_b(1'b0), .din_b('1),
      .reg_and(r_and), .bus(r_split)
   );

   regfile_bus_resolve #(.WIDTH(WIDTH)) u_joined (
      .wr_a(l_wr), .din_a(l_din), .wr_b(r_wr), .din_b(r_din),
      .reg_and(a_and), .bus(j_bus)
   );

   assign l_bus  = join_en ? j_bus : l_split;
   assign r_bus  = join_en ? j_bus : r_split;
   assign l_load = l_wr | (join_en & r_wr);
   assign r_load = r_wr | (join_en & l_wr);

`ifdef REGFILE_INCDEC_EN
   logic             step_en, wrap;
   logic [WIDTH-1:0] stepped;

   assign step_en = !join_en && !l_wr && (l_inc ^ l_dec);
   assign stepped = l_inc ? l_bus + WIDTH'(1) : l_bus - WIDTH'(1);
   assign wrap    = l_inc ? (&l_bus) : ~(|l_bus);

   always_ff @(posedge eclk or negedge erst_n) begin
      if (!erst_n) l_cy <= 1'b0;
      else         l_cy <= step_en & wrap;
   end
`endif

   always_ff @(posedge eclk or negedge erst_n) begin
      if (!erst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= RESET_VAL;
         l_dout <= '1;
         r_dout <= '1;
      end else begin
         l_dout <= l_bus;
         r_dout <= r_bus;
         for (int unsigned i = 0; i < NREGS; i++) begin
            if (sel[i]) begin
               if (i < NLEFT) begin
                  if (l_load) regs[i] <= l_bus;
`ifdef REGFILE_INCDEC_EN
                  else if (step_en) regs[i] <= stepped;
`endif
               end else if (r_load) begin
                  regs[i] <= r_bus;
               end
            end
         end
      end
   end

endmodule
